// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves immediate/register, direct and
// indirect operands into the bundle consumed by the ALU input mux.
package operand_fetch_pkg;
    typedef enum logic [1:0] {
        SRC_MEM_ADDR  = 2'd0,
        SRC_IMMEDIATE = 2'd1,
        SRC_INDIRECT  = 2'd2,
        SRC_REG       = 2'd3
    } data_src_t;
endpackage

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  data_src_t             req_source,
    input  logic [WIDTH-1:0]      req_operand,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output data_src_t             src_q,
    output logic [WIDTH-1:0]      operand_q,
    output logic [WIDTH-1:0]      mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_PTR,
        PTR_WAIT,
        RD_DATA,
        DATA_WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign mem_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            mem_rd    <= 1'b0;
            addr_q    <= '0;
            mem_data  <= '0;
            operand_q <= '0;
            src_q     <= SRC_REG;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        src_q     <= req_source;
                        operand_q <= req_operand;
                        req_ready <= 1'b0;
                        unique case (req_source)
                            SRC_MEM_ADDR: begin
                                addr_q <= req_operand[ADDR_WIDTH-1:0];
                                mem_rd <= 1'b1;
                                state  <= RD_DATA;
                            end
                            SRC_INDIRECT: begin
                                addr_q <= req_operand[ADDR_WIDTH-1:0];
                                mem_rd <= 1'b1;
                                state  <= RD_PTR;
                            end
                            default: begin
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
                RD_PTR: begin
                    mem_rd <= 1'b0;
                    state  <= PTR_WAIT;
                end
                PTR_WAIT: begin
                    // Pointer arrives now; upper bits beyond the address are dropped
                    addr_q <= mem_rdata[ADDR_WIDTH-1:0];
                    mem_rd <= 1'b1;
                    state  <= RD_DATA;
                end
                RD_DATA: begin
                    mem_rd <= 1'b0;
                    state  <= DATA_WAIT;
                end
                DATA_WAIT: begin
                    mem_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    mem_rd    <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a one-cycle-latency memory model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    data_src_t  req_source;
    logic [7:0] req_operand;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    data_src_t  src_q;
    logic [7:0] operand_q;
    logic [7:0] mem_data;

    int n_assert;
    int n_fail;
    int cyc;
    int lat;
    logic [7:0] mem [256];
    logic [7:0] rd_addr[$];
    int         rd_cyc[$];

    operand_fetch #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_source (req_source),
        .req_operand(req_operand),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src_q      (src_q),
        .operand_q  (operand_q),
        .mem_data   (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_addr.push_back(mem_addr);
            rd_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, " operand_q"}, 32'(operand_q), 32'd0);
        chk({tag, " src_q"}, 32'(src_q), 32'(SRC_REG));
    endtask

    // Present one request, drop req_valid after the accepting edge and
    // count cycles until out_valid (bounded).
    task automatic fetch(input data_src_t s, input logic [7:0] op,
                         input int exp_lat, input string tag);
        req_valid   = 1'b1;
        req_source  = s;
        req_operand = op;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        cyc         = 0;
        mem_rdata   = 8'h00;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_source  = SRC_REG;
        req_operand = 8'h00;
        out_ready   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        mem[8'h3C] = 8'hA5;
        mem[8'h20] = 8'h77;
        mem[8'h30] = 8'h40;
        mem[8'h40] = 8'h11;
        mem[8'h01] = 8'hC3;
        mem[8'h02] = 8'h50;
        mem[8'h50] = 8'h6E;

        step();
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Immediate
        rd_addr.delete();
        rd_cyc.delete();
        fetch(SRC_IMMEDIATE, 8'h42, 1, "imm");
        chk("imm operand_q", 32'(operand_q), 32'h42);
        chk("imm src_q", 32'(src_q), 32'(SRC_IMMEDIATE));
        step();
        chk("imm no mem_rd", 32'(rd_addr.size()), 32'd0);
        chk("imm back idle", 32'(req_ready), 32'd1);
        chk("imm valid drop", 32'(out_valid), 32'd0);

        // Direct memory operand
        rd_addr.delete();
        rd_cyc.delete();
        fetch(SRC_MEM_ADDR, 8'h10, 3, "mem");
        chk("mem data", 32'(mem_data), 32'h3C);
        chk("mem rd count", 32'(rd_addr.size()), 32'd1);
        if (rd_addr.size() >= 1)
            chk("mem rd addr", 32'(rd_addr[0]), 32'h10);
        step();

        // Indirect
        rd_addr.delete();
        rd_cyc.delete();
        fetch(SRC_INDIRECT, 8'h10, 5, "ind");
        chk("ind data", 32'(mem_data), 32'hA5);
        chk("ind src_q", 32'(src_q), 32'(SRC_INDIRECT));
        chk("ind rd count", 32'(rd_addr.size()), 32'd2);
        if (rd_addr.size() >= 2) begin
            chk("ind ptr addr", 32'(rd_addr[0]), 32'h10);
            chk("ind data addr", 32'(rd_addr[1]), 32'h3C);
            chk("ind rd spacing", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);
        end
        step();

        // Backpressure with toggling request inputs
        out_ready = 1'b0;
        fetch(SRC_MEM_ADDR, 8'h20, 3, "hold");
        for (int i = 0; i < 4; i++) begin
            req_valid   = ~req_valid;
            req_source  = data_src_t'(2'(i));
            req_operand = 8'hF0 ^ 8'(i);
            step();
            chk("hold valid", 32'(out_valid), 32'd1);
            chk("hold ready", 32'(req_ready), 32'd0);
            chk("hold data", 32'(mem_data), 32'h77);
            chk("hold operand", 32'(operand_q), 32'h20);
            chk("hold src", 32'(src_q), 32'(SRC_MEM_ADDR));
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold release valid", 32'(out_valid), 32'd0);
        chk("hold release ready", 32'(req_ready), 32'd1);

        // Register source keeps the previous memory data
        fetch(SRC_REG, 8'h99, 1, "reg");
        chk("reg mem_data kept", 32'(mem_data), 32'h77);
        chk("reg operand_q", 32'(operand_q), 32'h99);
        step();

        // Reset pulse during PTR_WAIT
        req_valid   = 1'b1;
        req_source  = SRC_INDIRECT;
        req_operand = 8'h30;
        step();
        req_valid = 1'b0;
        step();
        chk("rst ptr_wait mem_rd", 32'(mem_rd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #2;
        rst_n = 1'b1;
        rd_addr.delete();
        rd_cyc.delete();
        fetch(SRC_REG, 8'h5A, 1, "postrst");
        chk("postrst operand_q", 32'(operand_q), 32'h5A);
        chk("postrst mem_data", 32'(mem_data), 32'h00);
        chk("postrst no reads", 32'(rd_addr.size()), 32'd0);
        step();

        // Back-to-back with req_valid held
        req_valid   = 1'b1;
        req_source  = SRC_MEM_ADDR;
        req_operand = 8'h01;
        step();
        lat = 1;
        while (!out_valid && lat < 16) begin
            step();
            lat++;
        end
        chk("b2b first latency", 32'(lat), 32'd3);
        chk("b2b first data", 32'(mem_data), 32'hC3);
        req_source  = SRC_INDIRECT;
        req_operand = 8'h02;
        step();
        chk("b2b bubble ready", 32'(req_ready), 32'd1);
        chk("b2b bubble valid", 32'(out_valid), 32'd0);
        step();
        chk("b2b second accepted", 32'(req_ready), 32'd0);
        chk("b2b second src", 32'(src_q), 32'(SRC_INDIRECT));
        chk("b2b second operand", 32'(operand_q), 32'h02);
        req_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            step();
            lat++;
        end
        chk("b2b second latency", 32'(lat), 32'd5);
        chk("b2b second data", 32'(mem_data), 32'h6E);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data and operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: data-memory address width, with ADDR_WIDTH <= WIDTH.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid, input, 1: decoder presents a fetch request.
REQ-006 SHALL have port req_ready, output, 1: block can accept a request.
REQ-007 SHALL have port req_source, input, data_src_t: operand source (SRC_MEM_ADDR, SRC_IMMEDIATE, SRC_INDIRECT, SRC_REG).
REQ-008 SHALL have port req_operand, input, WIDTH: decoded operand field.
REQ-009 SHALL have port mem_rd, output, 1: data-memory read strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_WIDTH: data-memory read address.
REQ-011 SHALL have port mem_rdata, input, WIDTH: memory read data, valid exactly one cycle after the cycle mem_rd=1.
REQ-012 SHALL have port out_valid, output, 1: fetch complete; outputs stable.
REQ-013 SHALL have port out_ready, input, 1: ALU input mux stage consumes the result.
REQ-014 SHALL have port src_q, output, data_src_t: registered req_source, which drives the ALU input mux source select.
REQ-015 SHALL have port operand_q, output, WIDTH: registered req_operand, which drives the ALU input mux id_operand.
REQ-016 SHALL have port mem_data, output, WIDTH: fetched memory operand, which drives the ALU input mux mem_data.

Function
REQ-017 SHALL implement the FSM states IDLE, RD_PTR, PTR_WAIT, RD_DATA, DATA_WAIT and DONE.
REQ-018 SHALL assert req_ready=1 only in IDLE; a request is accepted on the edge where req_valid=1 and req_ready=1, capturing req_source and req_operand into src_q and operand_q.
REQ-019 SHALL, on acceptance, transition as follows: SRC_MEM_ADDR -> RD_DATA with addr_q=req_operand[ADDR_WIDTH-1:0]; SRC_INDIRECT -> RD_PTR with addr_q=req_operand[ADDR_WIDTH-1:0]; SRC_IMMEDIATE or SRC_REG -> DONE with no memory access.
REQ-020 SHALL assert mem_rd=1 only in RD_PTR and RD_DATA, with mem_addr=addr_q; mem_rd SHALL be 0 in all other states.
REQ-021 SHALL transition RD_PTR -> PTR_WAIT, and PTR_WAIT -> RD_DATA, loading addr_q with mem_rdata[ADDR_WIDTH-1:0].
REQ-022 SHALL transition RD_DATA -> DATA_WAIT, and DATA_WAIT -> DONE, loading mem_data with mem_rdata.
REQ-023 SHALL assert out_valid=1 only in DONE; DONE SHALL hold until out_ready=1, then transition to IDLE.
REQ-024 SHALL give out_valid latency, counted in cycles after the accepting edge, of: IMMEDIATE/REG 1, MEM_ADDR 3, INDIRECT 5.
REQ-025 SHALL keep src_q, operand_q and mem_data stable while out_valid=1, regardless of the values on req_*.
REQ-026 SHALL leave mem_data holding its previous value for IMMEDIATE/REG requests.
REQ-027 SHALL ignore req_valid outside IDLE; there is one IDLE bubble between back-to-back requests, and no request is accepted in the same cycle that DONE is consumed.
REQ-028 SHALL ignore the upper WIDTH-ADDR_WIDTH bits of both the pointer and the operand when forming addresses, with no error flag.
REQ-029 SHALL ignore out_ready in every state other than DONE.

Reset
REQ-030 SHALL, with rst_n=0, asynchronously force state=IDLE, req_ready=1, out_valid=0, mem_rd=0, mem_addr=0, addr_q=0, mem_data=0, operand_q=0, src_q=SRC_REG.
REQ-031 SHALL abandon any fetch in progress when reset asserts mid-fetch (any non-IDLE state); no out_valid SHALL follow, and the first edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-032 SHALL cover: IMMEDIATE, operand 0x42, out_ready=1 -> out_valid one cycle after accept, operand_q=0x42, mem_rd never asserted.
REQ-033 SHALL cover: MEM_ADDR 0x10 with mem[0x10]=0x3C -> single mem_rd at addr 0x10, out_valid 3 cycles after accept, mem_data=0x3C.
REQ-034 SHALL cover: INDIRECT 0x10 with mem[0x10]=0x3C and mem[0x3C]=0xA5 -> mem_rd at 0x10, then at 0x3C two cycles later; out_valid at cycle 5 with mem_data=0xA5.
REQ-035 SHALL cover: MEM_ADDR result with out_ready=0 for 4 cycles while req_* toggles -> out_valid and outputs held, req_ready=0, then IDLE one cycle after out_ready=1.
REQ-036 SHALL cover: rst_n pulsed low during PTR_WAIT of an INDIRECT fetch -> all outputs at reset values immediately, no out_valid; a following REG request completes in 1 cycle.
REQ-037 SHALL cover: back-to-back MEM_ADDR 0x01 then INDIRECT 0x02 with req_valid held high -> the second request is accepted exactly one cycle after DONE is consumed.
